// File: rtl/alu_bank_2b.sv
// Eight-lane 16-bit ALU stage with a one-deep skid buffer in front of the result register.
// Each lane applies its own packed action to operand A/B; results leave in acceptance order.
module alu_bank_2b #(
    parameter int STAGE_ID = 0,
    parameter int ACT_LEN  = 25,
    parameter int width_2B = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           alu_in_valid,
    input  logic [127:0]   alu_in_2B_1,
    input  logic [127:0]   alu_in_2B_2,
    input  logic [255:0]   phv_remain_data,
    input  logic [624:0]   action_in,
    input  logic           action_in_valid,
    output logic           ready_out,
    output logic           res_valid,
    output logic [127:0]   res_2B,
    output logic [255:0]   res_remain,
    input  logic           ready_in,
    output logic [31:0]    phv_cnt
);

    localparam int N_CONT = 8;
    localparam int OP_W   = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Immediate forms take their operand from B, so every op reduces to A, B, A+B or A-B.
    function automatic logic [15:0] alu_op(
        input logic [3:0]  op,
        input logic [15:0] a,
        input logic [15:0] b,
        input logic        act_valid
    );
        logic [15:0] r;
        r = a;
        if (act_valid) begin
            case (op)
                4'b0001: r = a + b;
                4'b0010: r = a - b;
                4'b1001: r = a + b;
                4'b1010: r = a - b;
                4'b1110: r = b;
                default: r = a;
            endcase
        end else begin
            r = a;
        end
        return r;
    endfunction

    state_t         state_q, state_d;
    logic           ready_out_q, ready_out_d;
    logic           res_valid_q, res_valid_d;
    logic [127:0]   out_res_q, out_res_d;
    logic [255:0]   out_rem_q, out_rem_d;
    logic [127:0]   skid_res_q, skid_res_d;
    logic [255:0]   skid_rem_q, skid_rem_d;
    logic [31:0]    phv_cnt_q, phv_cnt_d;

    logic [127:0]   alu_res_s;
    logic           accept_s;
    logic           transfer_s;
    logic           unused_s;

    assign accept_s   = alu_in_valid && ready_out_q;
    assign transfer_s = res_valid_q && ready_in;

    // Only the opcode field of each container action is decoded; the rest is carried for width only.
    assign unused_s = (^action_in) ^ (STAGE_ID == 32'sd0) ^ (ACT_LEN == 32'sd0)
                      ^ (width_2B == 32'sd0);

    // Per-container ALU evaluation on the incoming operand beat.
    always_comb begin
        alu_res_s = 128'd0;
        for (int i = 0; i < N_CONT; i++) begin
            alu_res_s[i*16 +: 16] = alu_op(
                action_in[(i+2)*ACT_LEN-1 -: OP_W],
                alu_in_2B_1[i*16 +: 16],
                alu_in_2B_2[i*16 +: 16],
                action_in_valid
            );
        end
    end

    // Occupancy state machine steering new beats into the output or skid register.
    always_comb begin
        state_d    = state_q;
        out_res_d  = out_res_q;
        out_rem_d  = out_rem_q;
        skid_res_d = skid_res_q;
        skid_rem_d = skid_rem_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d   = ST_ONE;
                    out_res_d = alu_res_s;
                    out_rem_d = phv_remain_data;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && transfer_s) begin
                    state_d   = ST_ONE;
                    out_res_d = alu_res_s;
                    out_rem_d = phv_remain_data;
                end else if (accept_s) begin
                    state_d    = ST_TWO;
                    skid_res_d = alu_res_s;
                    skid_rem_d = phv_remain_data;
                end else if (transfer_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_TWO: begin
                // ready_out is low here, so accept_s cannot be set.
                if (transfer_s) begin
                    state_d   = ST_ONE;
                    out_res_d = skid_res_q;
                    out_rem_d = skid_rem_q;
                end else begin
                    state_d = ST_TWO;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Handshake flags follow the next state so they change on the same edge as it.
    always_comb begin
        ready_out_d = 1'b1;
        res_valid_d = 1'b0;
        if (state_d == ST_TWO) begin
            ready_out_d = 1'b0;
        end else begin
            ready_out_d = 1'b1;
        end
        if (state_d == ST_EMPTY) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = 1'b1;
        end
    end

    // Transfer counter, wrapping naturally at 32 bits.
    always_comb begin
        phv_cnt_d = phv_cnt_q;
        if (transfer_s) begin
            phv_cnt_d = phv_cnt_q + 32'd1;
        end else begin
            phv_cnt_d = phv_cnt_q;
        end
    end

    // State, data and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            ready_out_q <= 1'b1;
            res_valid_q <= 1'b0;
            out_res_q   <= 128'd0;
            out_rem_q   <= 256'd0;
            skid_res_q  <= 128'd0;
            skid_rem_q  <= 256'd0;
            phv_cnt_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            ready_out_q <= ready_out_d;
            res_valid_q <= res_valid_d;
            out_res_q   <= out_res_d;
            out_rem_q   <= out_rem_d;
            skid_res_q  <= skid_res_d;
            skid_rem_q  <= skid_rem_d;
            phv_cnt_q   <= phv_cnt_d;
        end
    end

    assign ready_out  = ready_out_q;
    assign res_valid  = res_valid_q;
    assign res_2B     = out_res_q;
    assign res_remain = out_rem_q;
    assign phv_cnt    = phv_cnt_q;

endmodule
